adc_scan_ctrl: RTL

Conversion scheduler for the ADC front end. On a programmable period it scans the enabled analog-mux channels in ascending order. For each channel it drives the mux select, waits a settling time, pulses a conversion request to the ADC serial interface, and captures the returned 12-bit word. Each captured word is presented to the downstream DSP path on a valid/ready port tagged with its channel number, and the block keeps sticky error flags for dropped samples, missed periods and ADC timeouts.

---
 rtl/adc_scan_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: periodic ADC channel scanner.
//
// Each period tick starts a scan over the channels enabled in ch_mask_i, in
// ascending order. For every channel the block drives the mux select, waits
// SETTLE_CYCLES, issues a one-cycle conversion request and waits up to
// TIMEOUT_CYCLES for the ADC result. Results go to a one-entry valid/ready
// output register tagged with the channel number.
//
// Ports:
//   sck, rst_n          clock, asynchronous active-low reset
//   en_i                scan enable (also gates the period timer)
//   period_i            scan start interval minus one
//   ch_mask_i           channel enable mask, sampled at scan start
//   clr_i               clear sticky flags
//   ch_sel_o            analog mux select
//   conv_req_o          one-cycle conversion request
//   adc_data_i/valid_i  ADC result and strobe (only honoured while waiting)
//   sample_o/ch_o       captured sample and its channel
//   sample_valid_o      sample available; sample_ready_i accepts it
//   busy_o              scan in progress
//   drop_o/miss_o/timeout_o  sticky error flags
module adc_scan_ctrl #(
  parameter int DATA_W         = 12,
  parameter int NUM_CH         = 4,
  parameter int CH_W           = 2,
  parameter int PERIOD_W       = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                sck,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [NUM_CH-1:0]   ch_mask_i,
  input  logic                clr_i,
  output logic [CH_W-1:0]     ch_sel_o,
  output logic                conv_req_o,
  input  logic [DATA_W-1:0]   adc_data_i,
  input  logic                adc_valid_i,
  output logic [DATA_W-1:0]   sample_o,
  output logic [CH_W-1:0]     sample_ch_o,
  output logic                sample_valid_o,
  input  logic                sample_ready_i,
  output logic                busy_o,
  output logic                drop_o,
  output logic                miss_o,
  output logic                timeout_o
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, REQ, WAIT} state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] count_q, count_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [TO_W-1:0]     tout_q, tout_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [CH_W-1:0]     sample_ch_q, sample_ch_d;
  logic                valid_q, valid_d;
  logic                drop_q, drop_d;
  logic                miss_q, miss_d;
  logic                timeout_q, timeout_d;

  logic                tick;
  logic                capture;
  logic                tout_evt;
  logic                drop_evt;
  logic                xfer;
  logic [NUM_CH-1:0]   rem_clr;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    logic found;
    lowest_set = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (m[i] && !found) begin
        lowest_set = CH_W'(i);
        found      = 1'b1;
      end
    end
  endfunction

  // Period timer: held at zero while disabled, so the first tick lands in
  // the first enabled cycle.
  always_comb begin
    tick = en_i && (count_q == '0);
    if (!en_i)     count_d = '0;
    else if (tick) count_d = period_i;
    else           count_d = count_q - PERIOD_W'(1);
  end

  // Remaining channels after the current one completes. Scanning is
  // ascending, so the lowest remaining bit is the next higher channel.
  always_comb begin
    rem_clr       = rem_q;
    rem_clr[ch_q] = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    tout_d   = tout_q;
    ch_d     = ch_q;
    rem_d    = rem_q;
    capture  = 1'b0;
    tout_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick && (ch_mask_i != '0)) begin
          rem_d    = ch_mask_i;
          ch_d     = lowest_set(ch_mask_i);
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_d  = REQ;
        else                                       settle_d = settle_q + SET_W'(1);
      end
      REQ: begin
        tout_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (adc_valid_i)                              capture  = 1'b1;
        else if (tout_q == TO_W'(TIMEOUT_CYCLES - 1)) tout_evt = 1'b1;
        else                                          tout_d   = tout_q + TO_W'(1);
        if (capture || tout_evt) begin
          rem_d = rem_clr;
          if (en_i && (rem_clr != '0)) begin
            ch_d     = lowest_set(rem_clr);
            settle_d = '0;
            state_d  = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-entry output slot; a capture may replace data leaving the same cycle.
  always_comb begin
    xfer        = valid_q && sample_ready_i;
    sample_d    = sample_q;
    sample_ch_d = sample_ch_q;
    valid_d     = valid_q && !xfer;
    drop_evt    = 1'b0;
    if (capture) begin
      if (!valid_q || xfer) begin
        sample_d    = adc_data_i;
        sample_ch_d = ch_q;
        valid_d     = 1'b1;
      end else begin
        drop_evt = 1'b1;
      end
    end
  end

  // Sticky flags: a set event in the clearing cycle takes priority.
  always_comb begin
    drop_d    = drop_q;
    miss_d    = miss_q;
    timeout_d = timeout_q;
    if (drop_evt)                       drop_d    = 1'b1;
    else if (clr_i)                     drop_d    = 1'b0;
    if (tick && (state_q != IDLE))      miss_d    = 1'b1;
    else if (clr_i)                     miss_d    = 1'b0;
    if (tout_evt)                       timeout_d = 1'b1;
    else if (clr_i)                     timeout_d = 1'b0;
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      settle_q    <= '0;
      tout_q      <= '0;
      ch_q        <= '0;
      rem_q       <= '0;
      sample_q    <= '0;
      sample_ch_q <= '0;
      valid_q     <= 1'b0;
      drop_q      <= 1'b0;
      miss_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      settle_q    <= settle_d;
      tout_q      <= tout_d;
      ch_q        <= ch_d;
      rem_q       <= rem_d;
      sample_q    <= sample_d;
      sample_ch_q <= sample_ch_d;
      valid_q     <= valid_d;
      drop_q      <= drop_d;
      miss_q      <= miss_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ch_sel_o       = ch_q;
  assign conv_req_o     = (state_q == REQ);
  assign busy_o         = (state_q != IDLE);
  assign sample_o       = sample_q;
  assign sample_ch_o    = sample_ch_q;
  assign sample_valid_o = valid_q;
  assign drop_o         = drop_q;
  assign miss_o         = miss_q;
  assign timeout_o      = timeout_q;

endmodule
